// File: rtl/alu_cc.sv
// Execution-stage ALU producing Result and {N,Z,V,C} with SCC strobe to the PSR.
// Define ALU_CC_MUL_EN to build the iterative unsigned multiplier (opcode C).
module alu_cc #(
  parameter int unsigned DATAWIDTH_BUS = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [3:0]               i_opcode,
  input  logic [DATAWIDTH_BUS-1:0] i_a,
  input  logic [DATAWIDTH_BUS-1:0] i_b,
  input  logic                     i_setcc,
  input  logic                     i_carry_in,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [DATAWIDTH_BUS-1:0] o_result,
  output logic [3:0]               o_flags,
  output logic                     o_scc
);

  localparam int unsigned W   = DATAWIDTH_BUS;
  localparam int unsigned WP1 = W + 1;
  localparam int unsigned SHW = $clog2(W);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDX = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBX = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ANDN = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_MOVB = 4'hB;

  logic [W-1:0]   r_result, w_result_nxt;
  logic [3:0]     r_flags, w_flags_nxt;
  logic           r_done, w_done_nxt;
  logic           r_scc, w_scc_nxt;

  logic           w_cin;
  logic [SHW-1:0] w_shamt;
  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [W-1:0]   w_sc_result;
  logic           w_sc_v;
  logic           w_sc_c;
  logic [3:0]     w_sc_flags;

  // Single-cycle datapath; the carry-in only applies to the extended forms
  always_comb begin
    w_cin       = i_carry_in & ((i_opcode == OP_ADDX) | (i_opcode == OP_SUBX));
    w_shamt     = i_b[SHW-1:0];
    w_add       = {1'b0, i_a} + {1'b0, i_b} + WP1'(w_cin);
    w_sub       = {1'b0, i_a} - {1'b0, i_b} - WP1'(w_cin);
    w_sc_result = i_a;
    w_sc_v      = 1'b0;
    w_sc_c      = 1'b0;
    case (i_opcode)
      OP_ADD, OP_ADDX: begin
        w_sc_result = w_add[W-1:0];
        w_sc_c      = w_add[W];
        w_sc_v      = (i_a[W-1] == i_b[W-1]) && (w_add[W-1] != i_a[W-1]);
      end
      OP_SUB, OP_SUBX: begin
        w_sc_result = w_sub[W-1:0];
        w_sc_c      = w_sub[W];
        w_sc_v      = (i_a[W-1] != i_b[W-1]) && (w_sub[W-1] != i_a[W-1]);
      end
      OP_AND:  w_sc_result = i_a & i_b;
      OP_OR:   w_sc_result = i_a | i_b;
      OP_XOR:  w_sc_result = i_a ^ i_b;
      OP_ANDN: w_sc_result = i_a & ~i_b;
      OP_SLL:  w_sc_result = i_a << w_shamt;
      OP_SRL:  w_sc_result = i_a >> w_shamt;
      OP_SRA:  w_sc_result = W'($signed(i_a) >>> w_shamt);
      OP_MOVB: w_sc_result = i_b;
      default: w_sc_result = i_a;
    endcase
    w_sc_flags = {w_sc_result[W-1], (w_sc_result == '0), w_sc_v, w_sc_c};
  end

`ifdef ALU_CC_MUL_EN
  localparam int unsigned W2      = 2 * W;
  localparam logic [3:0]  OP_UMUL = 4'hC;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [SHW-1:0] r_cnt, w_cnt_nxt;
  logic [W2-1:0]  r_acc, w_acc_nxt;
  logic [W2-1:0]  r_mcand, w_mcand_nxt;
  logic [W-1:0]   r_mplier, w_mplier_nxt;
  logic           r_setcc, w_setcc_nxt;
  logic [W2-1:0]  w_acc_step;

  // Next-state: shift-add consumes one multiplier bit per clock
  always_comb begin
    w_result_nxt = r_result;
    w_flags_nxt  = r_flags;
    w_done_nxt   = 1'b0;
    w_scc_nxt    = 1'b0;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_setcc_nxt  = r_setcc;
    w_acc_step   = r_acc + (r_mplier[0] ? r_mcand : '0);
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_opcode == OP_UMUL) begin
            w_state_nxt  = S_MUL;
            w_cnt_nxt    = '0;
            w_acc_nxt    = '0;
            w_mcand_nxt  = {{W{1'b0}}, i_a};
            w_mplier_nxt = i_b;
            w_setcc_nxt  = i_setcc;
          end else begin
            w_result_nxt = w_sc_result;
            w_flags_nxt  = w_sc_flags;
            w_done_nxt   = 1'b1;
            w_scc_nxt    = i_setcc;
          end
        end
      end
      S_MUL: begin
        w_acc_nxt    = w_acc_step;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + SHW'(1);
        if (r_cnt == SHW'(W - 1)) begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_result_nxt = w_acc_step[W-1:0];
          w_flags_nxt  = {w_acc_step[W-1], (w_acc_step[W-1:0] == '0),
                          (w_acc_step[W2-1:W] != '0), 1'b0};
          w_done_nxt   = 1'b1;
          w_scc_nxt    = r_setcc;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_setcc  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_setcc  <= w_setcc_nxt;
    end
  end

  assign o_busy = (r_state == S_MUL);
`else
  // Every accepted op completes next cycle; opcode C falls into the reserved default
  always_comb begin
    w_result_nxt = r_result;
    w_flags_nxt  = r_flags;
    w_done_nxt   = 1'b0;
    w_scc_nxt    = 1'b0;
    if (i_start) begin
      w_result_nxt = w_sc_result;
      w_flags_nxt  = w_sc_flags;
      w_done_nxt   = 1'b1;
      w_scc_nxt    = i_setcc;
    end
  end

  assign o_busy = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result <= '0;
      r_flags  <= 4'b0000;
      r_done   <= 1'b0;
      r_scc    <= 1'b0;
    end else begin
      r_result <= w_result_nxt;
      r_flags  <= w_flags_nxt;
      r_done   <= w_done_nxt;
      r_scc    <= w_scc_nxt;
    end
  end

  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_flags  = r_flags;
  assign o_scc    = r_scc;

endmodule
